rf_access_seq: RTL and testbench

Register-file access sequencer. It sits directly upstream of REGISTER_FILE_32x32 and drives its READ/WRITE, address and write-data pins. It decodes an instruction word and issues a one-cycle operand read. It latches DATA_R1/DATA_R2, because the file tri-states them when not reading, and presents the latched operands to the ALU. It then waits for the ALU result and issues a one-cycle write-back. READ and WRITE are never asserted together, which guarantees the file never sees its undefined READ=WRITE=1 case.

---
 rtl/rf_access_seq_pkg.sv | 40 ++++
 rtl/rf_access_seq_if.sv | 45 ++++
 rtl/rf_access_seq_decode.sv | 66 ++++++
 rtl/rf_access_seq.sv | 172 +++++++++++++++++
 tb/tb_rf_access_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_access_seq_pkg.sv
//==============================================================================
// Module : rf_access_seq_pkg
// Shared opcodes, instruction field ranges and FSM encoding for rf_access_seq.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package rf_access_seq_pkg;

  localparam logic [5:0] c_opc_rtype = 6'h00;
  localparam logic [5:0] c_opc_jmp   = 6'h02;
  localparam logic [5:0] c_opc_jal   = 6'h03;
  localparam logic [5:0] c_opc_beq   = 6'h04;
  localparam logic [5:0] c_opc_bne   = 6'h05;
  localparam logic [5:0] c_opc_sw    = 6'h2b;

  localparam int c_opc_msb = 31;
  localparam int c_opc_lsb = 26;
  localparam int c_rs_msb  = 25;
  localparam int c_rs_lsb  = 21;
  localparam int c_rt_msb  = 20;
  localparam int c_rt_lsb  = 16;
  localparam int c_rd_msb  = 15;
  localparam int c_rd_lsb  = 11;
  localparam int c_imm_msb = 15;
  localparam int c_imm_lsb = 0;

  localparam int c_imm_width = c_imm_msb - c_imm_lsb + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rf_access_seq_if.sv
//==============================================================================
// Module : rf_access_seq_if
// Control, ALU and register-file pins of the access sequencer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface rf_access_seq_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);

  logic                      start;
  logic [31:0]               instr;
  logic                      alu_done;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic [DATA_WIDTH-1:0]     rf_data_r1;
  logic [DATA_WIDTH-1:0]     rf_data_r2;
  logic                      rf_read;
  logic                      rf_write;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r1;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r2;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_w;
  logic [DATA_WIDTH-1:0]     rf_data_w;
  logic [DATA_WIDTH-1:0]     op1;
  logic [DATA_WIDTH-1:0]     op2;
  logic                      op_valid;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, instr, alu_done, alu_result, rf_data_r1, rf_data_r2,
    output rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w,
    output op1, op2, op_valid, busy, done
  );

  modport slave (
    output start, instr, alu_done, alu_result, rf_data_r1, rf_data_r2,
    input  rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w,
    input  op1, op2, op_valid, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/rf_access_seq_decode.sv
//==============================================================================
// Module : rf_access_decode
// Combinational instruction decode into register-file access controls.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module rf_access_decode
  import rf_access_seq_pkg::*;
#(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic [31:0]               i_instr,
  output logic [REG_ADDR_WIDTH-1:0] o_r1,
  output logic [REG_ADDR_WIDTH-1:0] o_r2,
  output logic [REG_ADDR_WIDTH-1:0] o_w,
  output logic [c_imm_width-1:0]    o_imm,
  output logic                      o_op2_imm,
  output logic                      o_wen,
  output logic                      o_skip_read
);

  logic [5:0] w_opc;
  logic       w_wen_raw;

  assign w_opc = i_instr[c_opc_msb:c_opc_lsb];
  assign o_imm = i_instr[c_imm_msb:c_imm_lsb];

  // Default row is the generic I-type: writes rt, immediate operand.
  always_comb begin
    o_r1        = i_instr[c_rs_msb:c_rs_lsb];
    o_r2        = i_instr[c_rt_msb:c_rt_lsb];
    o_w         = i_instr[c_rt_msb:c_rt_lsb];
    o_op2_imm   = 1'b1;
    o_skip_read = 1'b0;
    w_wen_raw   = 1'b1;
    case (w_opc)
      c_opc_rtype: begin
        o_w       = i_instr[c_rd_msb:c_rd_lsb];
        o_op2_imm = 1'b0;
      end
      c_opc_jmp: begin
        o_skip_read = 1'b1;
        w_wen_raw   = 1'b0;
      end
      c_opc_jal: begin
        o_skip_read = 1'b1;
        o_w         = REG_ADDR_WIDTH'(31);
      end
      c_opc_beq, c_opc_bne: begin
        o_op2_imm = 1'b0;
        w_wen_raw = 1'b0;
      end
      c_opc_sw: begin
        w_wen_raw = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_wen = w_wen_raw && !(ZERO_REG_PROTECT && (o_w == '0));

endmodule

`default_nettype wire

// File: rtl/rf_access_seq.sv
//==============================================================================
// Module : rf_access_seq
// Register-file access sequencer: decode, operand read, ALU wait, write-back.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module rf_access_seq
  import rf_access_seq_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_access_seq_if.master   bus
);

  state_t r_state;
  state_t w_next_state;

  logic [REG_ADDR_WIDTH-1:0] w_dec_r1;
  logic [REG_ADDR_WIDTH-1:0] w_dec_r2;
  logic [REG_ADDR_WIDTH-1:0] w_dec_w;
  logic [c_imm_width-1:0]    w_dec_imm;
  logic                      w_dec_op2_imm;
  logic                      w_dec_wen;
  logic                      w_dec_skip_read;

  logic [REG_ADDR_WIDTH-1:0] r_addr_r1;
  logic [REG_ADDR_WIDTH-1:0] r_addr_r2;
  logic [REG_ADDR_WIDTH-1:0] r_addr_w;
  logic [REG_ADDR_WIDTH-1:0] r_w;
  logic [DATA_WIDTH-1:0]     r_data_w;
  logic [DATA_WIDTH-1:0]     r_op1;
  logic [DATA_WIDTH-1:0]     r_op2;
  logic [c_imm_width-1:0]    r_imm;
  logic                      r_op2_imm;
  logic                      r_wen;

  logic w_rf_read;
  logic w_rf_write;
  logic w_op_valid;
  logic w_busy;
  logic w_done;
  logic w_accept;
  logic w_alu_take;

  function automatic logic [DATA_WIDTH-1:0] sext_imm(input logic [c_imm_width-1:0] imm);
    return {{(DATA_WIDTH-c_imm_width){imm[c_imm_width-1]}}, imm};
  endfunction

  rf_access_decode #(
    .REG_ADDR_WIDTH   (REG_ADDR_WIDTH),
    .ZERO_REG_PROTECT (ZERO_REG_PROTECT)
  ) u_decode (
    .i_instr     (bus.instr),
    .o_r1        (w_dec_r1),
    .o_r2        (w_dec_r2),
    .o_w         (w_dec_w),
    .o_imm       (w_dec_imm),
    .o_op2_imm   (w_dec_op2_imm),
    .o_wen       (w_dec_wen),
    .o_skip_read (w_dec_skip_read)
  );

  assign w_accept   = (r_state == ST_IDLE) && bus.start;
  assign w_alu_take = (r_state == ST_EXEC) && bus.alu_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  always_comb begin
    w_next_state = r_state;
    w_rf_read    = 1'b0;
    w_rf_write   = 1'b0;
    w_op_valid   = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_next_state = w_dec_skip_read ? ST_EXEC : ST_READ;
        end
      end
      ST_READ: begin
        w_rf_read    = 1'b1;
        w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        w_op_valid = 1'b1;
        if (bus.alu_done) begin
          w_next_state = r_wen ? ST_WB : ST_FIN;
        end
      end
      ST_WB: begin
        w_rf_write   = 1'b1;
        w_next_state = ST_FIN;
      end
      ST_FIN: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_r1 <= '0;
      r_addr_r2 <= '0;
      r_addr_w  <= '0;
      r_w       <= '0;
      r_data_w  <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_imm     <= '0;
      r_op2_imm <= 1'b0;
      r_wen     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_w       <= w_dec_w;
        r_imm     <= w_dec_imm;
        r_op2_imm <= w_dec_op2_imm;
        r_wen     <= w_dec_wen;
        // Read addresses only move for instructions that actually read.
        if (w_dec_skip_read) begin
          r_op1 <= '0;
          r_op2 <= sext_imm(w_dec_imm);
        end else begin
          r_addr_r1 <= w_dec_r1;
          r_addr_r2 <= w_dec_r2;
        end
      end
      if (r_state == ST_READ) begin
        r_op1 <= bus.rf_data_r1;
        r_op2 <= r_op2_imm ? sext_imm(r_imm) : bus.rf_data_r2;
      end
      if (w_alu_take) begin
        r_data_w <= bus.alu_result;
        if (r_wen) begin
          r_addr_w <= r_w;
        end
      end
    end
  end

  assign bus.rf_read    = w_rf_read;
  assign bus.rf_write   = w_rf_write;
  assign bus.rf_addr_r1 = r_addr_r1;
  assign bus.rf_addr_r2 = r_addr_r2;
  assign bus.rf_addr_w  = r_addr_w;
  assign bus.rf_data_w  = r_data_w;
  assign bus.op1        = r_op1;
  assign bus.op2        = r_op2;
  assign bus.op_valid   = w_op_valid;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

`default_nettype wire

// File: tb/tb_rf_access_seq.sv
//==============================================================================
// Module : tb_rf_access_seq
// Self-checking bench for rf_access_seq with a behavioural register file.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_rf_access_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_access_seq_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bif ();

  rf_access_seq #(
    .DATA_WIDTH       (32),
    .REG_ADDR_WIDTH   (5),
    .ZERO_REG_PROTECT (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
  );

  logic [31:0] mem    [32];
  logic [31:0] ref_rf [32];
  logic [31:0] noise1 = '0;
  logic [31:0] noise2 = '0;
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_both = 0;

  // Register file: outputs float (modelled as noise) unless READ is high.
  always_comb bif.rf_data_r1 = bif.rf_read ? mem[bif.rf_addr_r1] : noise1;
  always_comb bif.rf_data_r2 = bif.rf_read ? mem[bif.rf_addr_r2] : noise2;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bif.rf_write) mem[bif.rf_addr_w] <= bif.rf_data_w;
  end

  always @(negedge clk) if (bif.rf_read && bif.rf_write) n_both++;

  typedef struct {
    bit          has_read;
    logic [4:0]  a1, a2, w;
    logic [31:0] op1, op2;
    bit          wen;
    int          lat;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] ins, input int wait_c);
    exp_t e;
    logic [5:0]  opc;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    bit          reg_op2;
    opc = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; imm = ins[15:0];
    e.has_read = !(opc == 6'h02 || opc == 6'h03);
    e.a1 = rs;
    e.a2 = rt;
    reg_op2 = (opc == 6'h00 || opc == 6'h04 || opc == 6'h05);
    e.op1 = e.has_read ? ref_rf[rs] : 32'd0;
    e.op2 = (e.has_read && reg_op2) ? ref_rf[rt] : {{16{imm[15]}}, imm};
    if (opc == 6'h00) begin e.w = rd; e.wen = 1; end
    else if (opc == 6'h03) begin e.w = 5'd31; e.wen = 1; end
    else if (opc == 6'h02 || opc == 6'h04 || opc == 6'h05 || opc == 6'h2b) begin e.w = rt; e.wen = 0; end
    else begin e.w = rt; e.wen = 1; end
    if (e.w == 5'd0) e.wen = 0;
    e.lat = (e.has_read ? 3 : 2) + (e.wen ? 1 : 0) + wait_c;
    return e;
  endfunction

  task automatic run_instr(input string tag, input logic [31:0] ins, input int wait_c,
                           input logic [31:0] res, input bit hold_start);
    exp_t        e;
    int          c, nread, nwrite, ex_cnt;
    logic [4:0]  a1, a2, wa;
    logic [31:0] op1o, op2o, wd;
    bit          got_done, seen_ex, rf_ok;
    e = predict(ins, wait_c);
    c = 0; nread = 0; nwrite = 0; ex_cnt = 0; got_done = 0; seen_ex = 0;
    a1 = '0; a2 = '0; wa = '0; op1o = '0; op2o = '0; wd = '0;
    @(negedge clk);
    bif.start = 1'b1; bif.instr = ins;
    bif.alu_done = 1'($urandom); bif.alu_result = $urandom;
    while (!got_done && c < 200) begin
      @(negedge clk);
      c++;
      if (bif.rf_read) begin nread++; a1 = bif.rf_addr_r1; a2 = bif.rf_addr_r2; end
      if (bif.rf_write) begin nwrite++; wa = bif.rf_addr_w; wd = bif.rf_data_w; end
      if (bif.op_valid && !seen_ex) begin seen_ex = 1; op1o = bif.op1; op2o = bif.op2; end
      if (bif.done) got_done = 1;
      noise1 = $urandom; noise2 = $urandom;
      bif.start = hold_start ? 1'b1 : 1'($urandom);
      bif.instr = $urandom;
      if (bif.op_valid) begin
        bif.alu_done   = (ex_cnt == wait_c);
        bif.alu_result = (ex_cnt == wait_c) ? res : $urandom;
        ex_cnt++;
      end else begin
        bif.alu_done = 1'($urandom); bif.alu_result = $urandom;
      end
    end
    chk({tag, " latency"}, 32'(c), 32'(e.lat));
    chk({tag, " read cycles"}, 32'(nread), e.has_read ? 32'd1 : 32'd0);
    if (e.has_read) begin
      chk({tag, " addr_r1"}, 32'(a1), 32'(e.a1));
      chk({tag, " addr_r2"}, 32'(a2), 32'(e.a2));
    end
    chk({tag, " op1"}, op1o, e.op1);
    chk({tag, " op2"}, op2o, e.op2);
    chk({tag, " write cycles"}, 32'(nwrite), e.wen ? 32'd1 : 32'd0);
    if (e.wen) begin
      chk({tag, " addr_w"}, 32'(wa), 32'(e.w));
      chk({tag, " data_w"}, wd, res);
      ref_rf[e.w] = res;
    end
    @(negedge clk);
    bif.start = 1'b0; bif.alu_done = 1'($urandom);
    chk({tag, " idle after done"}, 32'(bif.busy), 32'd0);
    rf_ok = 1;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_rf[i]) rf_ok = 0;
    chk({tag, " rf contents"}, 32'(rf_ok), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [5:0]  opc;
    bit          found;
    bif.start = 1'b0; bif.instr = '0; bif.alu_done = 1'b0; bif.alu_result = '0;

    // Preload the register file while the DUT is held in reset.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ref_rf[i] = (i == 2) ? 32'd5 : (i == 3) ? 32'd7 : $urandom;
      pl_en = 1'b1; pl_addr = 5'(i); pl_data = ref_rf[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
    chk("reset rf_read",  32'(bif.rf_read),  32'd0);
    chk("reset rf_write", 32'(bif.rf_write), 32'd0);
    chk("reset busy",     32'(bif.busy),     32'd0);
    chk("reset done",     32'(bif.done),     32'd0);
    chk("reset op_valid", 32'(bif.op_valid), 32'd0);
    chk("reset op1",      bif.op1,           32'd0);
    chk("reset op2",      bif.op2,           32'd0);
    chk("reset data_w",   bif.rf_data_w,     32'd0);
    chk("reset addrs",    32'({bif.rf_addr_r1, bif.rf_addr_r2, bif.rf_addr_w}), 32'd0);
    rst_n = 1'b1;

    run_instr("add r4",     32'h00432020, 0, 32'd12,       1'b0);
    run_instr("addi r5",    32'h2025FFFF, 2, 32'h1234_5678, 1'b0);
    run_instr("sw",         32'hAC220004, 0, 32'hCAFE_0001, 1'b0);
    run_instr("rtype rd0",  32'h00430020, 1, 32'hFFFF_0000, 1'b0);
    run_instr("jal",        32'h0C000010, 0, 32'h0000_0444, 1'b0);
    run_instr("jmp",        32'h08000123, 3, 32'h0BAD_0BAD, 1'b0);
    run_instr("beq",        32'h10430008, 0, 32'h0000_0001, 1'b0);
    run_instr("start held", 32'h00A62820, 10, 32'h7777_7777, 1'b1);

    // Reset asserted mid write-back must abort the write.
    @(negedge clk);
    bif.start = 1'b1; bif.instr = 32'h00432020; bif.alu_done = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bif.rf_write) found = 1;
      else begin
        bif.start = 1'b0;
        bif.alu_done = bif.op_valid; bif.alu_result = 32'hDEAD_BEEF;
      end
    end
    chk("rst wb reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    bif.start = 1'b0; bif.alu_done = 1'b0;
    #1;
    chk("rst wb rf_write", 32'(bif.rf_write), 32'd0);
    chk("rst wb busy",     32'(bif.busy),     32'd0);
    chk("rst wb data_w",   bif.rf_data_w,     32'd0);
    @(posedge clk); #1;
    chk("rst wb r4 kept",  mem[4], ref_rf[4]);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0: opc = 6'h00;
        1: opc = 6'h02;
        2: opc = 6'h03;
        3: opc = 6'h04;
        4: opc = 6'h05;
        5: opc = 6'h2b;
        default: opc = 6'($urandom);
      endcase
      ins = {opc, 26'($urandom)};
      run_instr("random", ins, int'($urandom_range(0, 4)), $urandom, 1'b0);
    end

    chk("read and write together", 32'(n_both), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
